// File: rtl/div_pkg.sv
// Shared encodings and constants for the sequential restoring divider.
package div_pkg;
  localparam int DP_W = 64;  // width of the RCA_sub datapath

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_restoring_divider_rca_sub.sv
// 64-bit ripple-carry subtractor: diff = a - b, computed as a + ~b + 1.
module RCA_sub
  import div_pkg::*;
(
  input  logic [DP_W-1:0] a,
  input  logic [DP_W-1:0] b,
  output logic [DP_W-1:0] diff,
  output logic            cout
);
  genvar i;
  // Each stage keeps its own carry so the chain is not one self-feeding vector.
  for (i = 0; i < DP_W; i++) begin : g_bit
    logic cin, co, p;
    if (i == 0) begin : g_first
      assign cin = 1'b1;
    end else begin : g_next
      assign cin = g_bit[i-1].co;
    end
    assign p       = a[i] ^ ~b[i];
    assign diff[i] = p ^ cin;
    assign co      = (a[i] & ~b[i]) | (cin & p);
  end
  assign cout = g_bit[DP_W-1].co;
endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock
// through a shared RCA_sub, results reported with a one-cycle done pulse.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] q, d;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   s, r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [DP_W-1:0]  sub_a, sub_b, diff;
  logic             cout_unused, unused_diff, trial_ok;

  assign s     = {r[WIDTH-1:0], q[WIDTH-1]};
  assign sub_a = DP_W'(s);
  assign sub_b = DP_W'(d);

  RCA_sub u_sub (
    .a    (sub_a),
    .b    (sub_b),
    .diff (diff),
    .cout (cout_unused)
  );

  assign unused_diff = ^diff[DP_W-2:WIDTH+1];
  assign trial_ok    = ~diff[DP_W-1];
  assign r_nxt       = trial_ok ? diff[WIDTH:0] : s;
  assign q_nxt       = {q[WIDTH-2:0], trial_ok};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            q           <= dividend;
            r           <= '0;
            d           <= divisor;
            div_by_zero <= (divisor == '0);
            busy        <= 1'b1;
            state       <= S_RUN;
            // A zero divisor skips straight to the last count so the result
            // appears one cycle later without running the datapath.
            cnt         <= (divisor == '0) ? CW'(WIDTH - 1) : '0;
          end
        end
        S_RUN: begin
          if (!div_by_zero) begin
            r <= r_nxt;
            q <= q_nxt;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
            if (div_by_zero) begin
              quotient  <= '1;
              remainder <= q;
            end else begin
              quotient  <= q_nxt;
              remainder <= r_nxt[WIDTH-1:0];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=16).
module tb_seq_restoring_divider;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for done; n counts cycles from start to done.
  task automatic run_div(input string tag, input logic [15:0] dd, input logic [15:0] dv,
                         input int exp_lat, input logic [15:0] eq, input logic [15:0] er,
                         input logic edz);
    int n;
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0; dividend = 16'hA5A5; divisor = 16'h0003;
    n = 1;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
    chk({tag, ".q"}, 32'(quotient), 32'(eq));
    chk({tag, ".r"}, 32'(remainder), 32'(er));
    chk({tag, ".dz"}, 32'(div_by_zero), 32'(edz));
    @(negedge clk);
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".hold"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    int n, k, seen;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.q", 32'(quotient), 32'd0);
    chk("rst.r", 32'(remainder), 32'd0);
    chk("rst.dz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    run_div("d100_7",   16'd100,   16'd7, 17, 16'd14,    16'd2,  1'b0);
    run_div("d65535_1", 16'd65535, 16'd1, 17, 16'd65535, 16'd0,  1'b0);
    run_div("d5_9",     16'd5,     16'd9, 17, 16'd0,     16'd5,  1'b0);
    run_div("d1234_0",  16'd1234,  16'd0,  2, 16'hFFFF,  16'd1234, 1'b1);
    run_div("d40000_200", 16'd40000, 16'd200, 17, 16'd200, 16'd0, 1'b0);

    // A second start while busy must be dropped.
    @(negedge clk);
    start = 1'b1; dividend = 16'd60000; divisor = 16'd250;
    @(negedge clk);
    start = 1'b0; n = 1;
    repeat (2) begin @(negedge clk); n++; end
    start = 1'b1; dividend = 16'd50; divisor = 16'd3;
    @(negedge clk); n++;
    start = 1'b0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("ign.lat", 32'(n), 32'd17);
    chk("ign.q", 32'(quotient), 32'd240);
    chk("ign.r", 32'(remainder), 32'd0);
    seen = 0;
    repeat (30) begin @(negedge clk); if (done) seen++; end
    chk("ign.no_second_done", 32'(seen), 32'd0);
    chk("ign.hold_q", 32'(quotient), 32'd240);

    // Reset in the middle of a run clears everything at once.
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.done", 32'(done), 32'd0);
    chk("mid_rst.q", 32'(quotient), 32'd0);
    chk("mid_rst.r", 32'(remainder), 32'd0);
    chk("mid_rst.state", 32'(dut.state), 32'd0);
    seen = 0;
    repeat (2) begin @(negedge clk); if (done) seen++; end
    rst_n = 1'b1;
    repeat (20) begin @(negedge clk); if (done) seen++; end
    chk("mid_rst.no_done", 32'(seen), 32'd0);
    run_div("d1000_3", 16'd1000, 16'd3, 17, 16'd333, 16'd1, 1'b0);

    // Start held high: a new division is accepted right after each DONE cycle.
    @(negedge clk);
    start = 1'b1; dividend = 16'd65000; divisor = 16'd340;
    k = 0;
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      if (done) begin
        chk($sformatf("b2b.pos%0d", k), 32'(c), 32'(17 + 18 * k));
        chk($sformatf("b2b.q%0d", k), 32'(quotient), 32'd191);
        chk($sformatf("b2b.r%0d", k), 32'(remainder), 32'd60);
        k++;
      end
    end
    chk("b2b.count", 32'(k), 32'd3);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("end.idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
